whitening_par: RTL
==================

WHITENING_PAR -- requirements
Module: whitening_par

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits processed per accepted beat (1..32).
REQ-002 SHALL have parameter LFSR_W, default 7: LFSR length.
REQ-003 SHALL have parameter POLY, default 7'b0010001: feedback tap mask, bit i set means stage i is XORed with the feedback bit; bit 0 is always implied.
REQ-004 SHALL have parameter LEN_W, default 16: width of the beat-count input.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port init, input, 1 bit: single-cycle start pulse that loads the seed and the length.
REQ-008 SHALL have port seed, input, LFSR_W-1 bits: whitening seed (the BLE channel index when LFSR_W=7).
REQ-009 SHALL have port len, input, LEN_W bits: number of beats in the packet, sampled on init.
REQ-010 SHALL have port bypass, input, 1 bit: passes data through unwhitened; sampled on init.
REQ-011 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-012 SHALL have port in_data, input, DATA_W bits: input beat; bit 0 is the first bit on air.
REQ-013 SHALL have port in_ready, output, 1 bit: input beat accepted when in_valid and in_ready are both high.
REQ-014 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-015 SHALL have port out_data, output, DATA_W bits: whitened beat.
REQ-016 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse issued when the last beat of the packet is transferred out.

Function
REQ-018 LFSR single step SHALL be: fb = lfsr[LFSR_W-1]; lfsr[0] <= fb; lfsr[i] <= lfsr[i-1] ^ (POLY[i] & fb) for i = 1..LFSR_W-1; the whitening bit for that step SHALL be fb taken before the shift.
REQ-019 Per accepted beat, SHALL apply DATA_W single steps combinationally: out bit k = in_data[k] ^ whitening bit of step k; the LFSR SHALL then hold the state after DATA_W steps.
REQ-020 Seed load on init SHALL be: lfsr[0] = 1; lfsr[i] = seed[LFSR_W-1-i] for i = 1..LFSR_W-1.
REQ-021 FSM SHALL have states IDLE, RUN and FLUSH. IDLE: in_ready = 0. On init with len != 0, go to RUN. On init with len = 0, stay in IDLE with no done pulse.
REQ-022 RUN: in_ready SHALL equal !out_valid || out_ready. Each accepted beat SHALL decrement the remaining-beat counter. Acceptance of the last beat SHALL move the FSM to FLUSH.
REQ-023 FLUSH: in_ready = 0. When the final beat transfers out (out_valid && out_ready), done SHALL pulse for exactly 1 cycle and the FSM SHALL go to IDLE.
REQ-024 Output SHALL be a single register stage: latency 1 cycle from acceptance to out_valid. out_data and out_valid SHALL stay stable while out_valid && !out_ready. Full throughput: 1 beat per cycle when out_ready = 1.
REQ-025 With bypass latched, out_data SHALL equal in_data and the LFSR SHALL be frozen; the handshake, counter and done behaviour SHALL be unchanged.
REQ-026 The LFSR SHALL advance only on accepted beats; it SHALL be unaffected by stalls.
REQ-027 init in any state, including RUN or FLUSH, SHALL take priority over everything else in that cycle: it reloads the LFSR, the counter and bypass, clears out_valid (the pending beat is discarded), issues no done, and applies REQ-021.
REQ-028 A beat presented in the same cycle as init SHALL NOT be accepted, because in_ready is 0 that cycle.

Reset
REQ-029 rst SHALL force: lfsr = 0, counter = 0, bypass latch = 0, FSM = IDLE, out_valid = 0, out_data = 0, in_ready = 0, done = 0.

Structure
REQ-030 The state encoding (IDLE/RUN/FLUSH) and the default POLY, LFSR_W and DATA_W values SHALL live in the shared header package, next to the existing channel-index width.
REQ-031 SHALL have one sub-module, lfsr_step_n: a combinational DATA_W-step LFSR advance that outputs the next state and the DATA_W-bit keystream.

Verification
REQ-032 Bench SHALL cover keystream: DATA_W=8, seed=0, len=2, in_data=0x00 twice, out_ready=1 -> out_data 0x40, then 0xB2, done pulses with the second output beat.
REQ-033 Bench SHALL cover round trip: random seed, len=64, random data; feed the output into a second instance with the same seed -> the original data is recovered bit-exact.
REQ-034 Bench SHALL cover backpressure: out_ready toggled randomly during len=16 -> output sequence identical to the out_ready=1 run, no beat lost or duplicated, out_data stable while stalled.
REQ-035 Bench SHALL cover bypass: bypass=1, len=4, data 0x11,0x22,0x33,0x44 -> identical output, done after the 4th beat.
REQ-036 Bench SHALL cover re-init: init asserted in RUN after 3 of 8 beats with out_valid high and out_ready=0 -> out_valid drops next cycle, no done, the new packet starts with the fresh seed keystream.
REQ-037 Bench SHALL cover reset: rst asserted mid-FLUSH -> all outputs 0 asynchronously; len=0 init afterwards -> FSM stays in IDLE, no done.

Source files
------------

// File: rtl/whitening_par_pkg.sv
// Shared definitions for the parallel BLE data whitener: default LFSR geometry,
// channel-index width and the control FSM encoding.
package whitening_par_pkg;

   localparam int CHAN_IDX_W = 6;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_LFSR_W = CHAN_IDX_W + 1;
   localparam logic [DEF_LFSR_W-1:0] DEF_POLY = 7'b0010001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } wh_state_e;

endpackage

// File: rtl/whitening_par_lfsr_step_n.sv
// Combinational multi-step Galois LFSR advance; bit k of the keystream is the
// feedback bit of step k, taken before that step's shift.
module lfsr_step_n
   import whitening_par_pkg::*;
#(
   parameter int                LFSR_W = DEF_LFSR_W,
   parameter int                STEPS  = DEF_DATA_W,
   parameter logic [LFSR_W-1:0] POLY   = DEF_POLY
) (
   input  logic [LFSR_W-1:0] state_i,
   output logic [LFSR_W-1:0] state_o,
   output logic [STEPS-1:0]  ks_o
);

   // Stage 0 always receives the feedback bit, so tap bit 0 is ignored.
   localparam logic [LFSR_W-1:0] TAPS = POLY & {{(LFSR_W-1){1'b1}}, 1'b0};

   // Unrolled chain of single steps
   always_comb begin
      logic [LFSR_W-1:0] s;
      logic              fb;
      s    = state_i;
      fb   = 1'b0;
      ks_o = {STEPS{1'b0}};
      for (int k = 0; k < STEPS; k++) begin
         fb      = s[LFSR_W-1];
         ks_o[k] = fb;
         s       = {s[LFSR_W-2:0], fb} ^ (TAPS & {LFSR_W{fb}});
      end
      state_o = s;
   end

endmodule

// File: rtl/whitening_par.sv
// Parallel data whitener: XORs each accepted beat with DATA_W LFSR keystream bits,
// counts beats of a packet and pulses done when the last beat leaves.
module whitening_par
   import whitening_par_pkg::*;
#(
   parameter int                DATA_W = DEF_DATA_W,
   parameter int                LFSR_W = DEF_LFSR_W,
   parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
   parameter int                LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic [LFSR_W-2:0] seed,
   input  logic [LEN_W-1:0]  len,
   input  logic              bypass,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              done
);

   localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   wh_state_e         state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step_s, seed_lfsr_s;
   logic [DATA_W-1:0] ks_s, out_data_q, out_data_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              bypass_q, bypass_d;
   logic              out_valid_q, out_valid_d;
   logic              accept_s, out_xfer_s, last_beat_s;

   lfsr_step_n #(
      .LFSR_W (LFSR_W),
      .STEPS  (DATA_W),
      .POLY   (POLY)
   ) u_step (
      .state_i (lfsr_q),
      .state_o (lfsr_step_s),
      .ks_o    (ks_s)
   );

   assign accept_s    = in_valid && in_ready;
   assign out_xfer_s  = out_valid_q && out_ready;
   assign last_beat_s = (cnt_q == CNT_ONE);
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;

   // Seed is bit-reversed into stages 1..LFSR_W-1; stage 0 starts at one
   always_comb begin
      seed_lfsr_s    = {LFSR_W{1'b0}};
      seed_lfsr_s[0] = 1'b1;
      for (int i = 1; i < LFSR_W; i++) begin
         seed_lfsr_s[i] = seed[LFSR_W-1-i];
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; init overrides whatever the current state would do
   always_comb begin
      state_d = state_q;
      if (init) begin
         if (len != CNT_ZERO) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN: begin
               if (accept_s && last_beat_s) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (out_xfer_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs; a beat is never taken in the same cycle as init
   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b0;
            done     = 1'b0;
         end
         ST_RUN: begin
            in_ready = !init && (!out_valid_q || out_ready);
            done     = 1'b0;
         end
         ST_FLUSH: begin
            in_ready = 1'b0;
            done     = !init && out_xfer_s;
         end
         default: begin
            in_ready = 1'b0;
            done     = 1'b0;
         end
      endcase
   end

   // Datapath next state: init reload, beat acceptance, or output drain
   always_comb begin
      lfsr_d      = lfsr_q;
      cnt_d       = cnt_q;
      bypass_d    = bypass_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (init) begin
         lfsr_d      = seed_lfsr_s;
         cnt_d       = len;
         bypass_d    = bypass;
         out_valid_d = 1'b0;
      end else if (accept_s) begin
         cnt_d       = cnt_q - CNT_ONE;
         out_valid_d = 1'b1;
         if (bypass_q) begin
            out_data_d = in_data;
         end else begin
            out_data_d = in_data ^ ks_s;
            lfsr_d     = lfsr_step_s;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q      <= {LFSR_W{1'b0}};
         cnt_q       <= CNT_ZERO;
         bypass_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
      end else begin
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         bypass_q    <= bypass_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule
